line_fill_merge: RTL and testbench

- Write-direction counterpart of the cache word-select path. Assembles a full cache line from a word-wide refill burst.
- Bursts are critical-word-first and wrap around the line.
- Merges a pending store word, under byte strobes, into the line as the matching beat arrives.
- Sits between the cache refill FSM (bus side) and the data-array write port. Forwards the critical word early to the pipeline.

---
 rtl/line_fill_merge.sv | 152 +++++++++++++++
 tb/tb_line_fill_merge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_merge.sv
// Assembles a cache line from a critical-word-first wrapping refill burst,
// merging a pending store word under byte strobes and forwarding the critical word.
module line_fill_merge #(
  parameter  int DATA_WIDTH      = 32,
  parameter  int Cache_line_size = 512,
  localparam int Addr_len        = $clog2(Cache_line_size / DATA_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [Addr_len-1:0]        start_offset,
  input  logic                       st_en,
  input  logic [Addr_len-1:0]        st_offset,
  input  logic [DATA_WIDTH-1:0]      st_wdata,
  input  logic [DATA_WIDTH/8-1:0]    st_wstrb,
  input  logic                       beat_valid,
  output logic                       beat_ready,
  input  logic [DATA_WIDTH-1:0]      beat_data,
  input  logic                       beat_last,
  output logic                       crit_valid,
  output logic [DATA_WIDTH-1:0]      crit_data,
  output logic                       line_valid,
  input  logic                       line_ready,
  output logic [Cache_line_size-1:0] line_data,
  output logic                       err
);

  localparam int NWORDS = Cache_line_size / DATA_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [Addr_len-1:0]        ptr_q, ptr_d;
  logic [Addr_len-1:0]        count_q, count_d;
  logic [Cache_line_size-1:0] line_q, line_d;
  logic                       crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0]      crit_data_q, crit_data_d;
  logic                       err_q, err_d;
  logic                       st_en_q, st_en_d;
  logic [Addr_len-1:0]        st_offset_q, st_offset_d;
  logic [DATA_WIDTH-1:0]      st_wdata_q, st_wdata_d;
  logic [NBYTES-1:0]          st_wstrb_q, st_wstrb_d;
  logic [DATA_WIDTH-1:0]      merged_word;

  // The store only touches the beat whose wrapped offset matches its own.
  always_comb begin
    merged_word = beat_data;
    if (st_en_q && (ptr_q == st_offset_q)) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (st_wstrb_q[i]) begin
          merged_word[8*i +: 8] = st_wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    err_d        = err_q;
    st_en_d      = st_en_q;
    st_offset_d  = st_offset_q;
    st_wdata_d   = st_wdata_q;
    st_wstrb_d   = st_wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          ptr_d       = start_offset;
          count_d     = '0;
          st_en_d     = st_en;
          st_offset_d = st_offset;
          st_wdata_d  = st_wdata;
          st_wstrb_d  = st_wstrb;
          line_d      = '0;
          err_d       = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (beat_valid) begin
          line_d[int'(ptr_q) * DATA_WIDTH +: DATA_WIDTH] = merged_word;
          ptr_d   = ptr_q + Addr_len'(1);
          count_d = count_q + Addr_len'(1);
          if (count_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = merged_word;
          end
          // A full burst without beat_last, or a short one ending early, is a length error.
          if (count_q == Addr_len'(NWORDS - 1)) begin
            state_d = DONE;
            if (!beat_last) err_d = 1'b1;
          end else if (beat_last) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (line_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      err_q        <= 1'b0;
      st_en_q      <= 1'b0;
      st_offset_q  <= '0;
      st_wdata_q   <= '0;
      st_wstrb_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      err_q        <= err_d;
      st_en_q      <= st_en_d;
      st_offset_q  <= st_offset_d;
      st_wdata_q   <= st_wdata_d;
      st_wstrb_q   <= st_wstrb_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign beat_ready  = (state_q == FILL);
  assign line_valid  = (state_q == DONE);
  assign line_data   = line_q;
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_line_fill_merge.sv
// Randomized self-checking bench for line_fill_merge: each fill is predicted from
// the burst rules (wrapped word placement, byte merge, length error) by a reference model.
module tb_line_fill_merge;

  localparam int DW = 32;
  localparam int LW = 512;
  localparam int N  = LW / DW;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] start_offset;
  logic          st_en;
  logic [AW-1:0] st_offset;
  logic [DW-1:0] st_wdata;
  logic [3:0]    st_wstrb;
  logic          beat_valid;
  logic          beat_ready;
  logic [DW-1:0] beat_data;
  logic          beat_last;
  logic          crit_valid;
  logic [DW-1:0] crit_data;
  logic          line_valid;
  logic          line_ready;
  logic [LW-1:0] line_data;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] beat_words [N];
  logic [LW-1:0] exp_line;
  logic [DW-1:0] exp_crit;
  logic          exp_err;

  line_fill_merge #(.DATA_WIDTH(DW), .Cache_line_size(LW)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .start_offset(start_offset),
    .st_en(st_en), .st_offset(st_offset), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data), .beat_last(beat_last),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] base, input logic [DW-1:0] wd,
                                               input logic [3:0] sb);
    logic [DW-1:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (sb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Reference: beat k lands at (off+k) mod N; last_idx<0 means no beat_last at all.
  task automatic build_model(input int off, input bit sen, input int soff, input logic [DW-1:0] swd,
                             input logic [3:0] sws, input int nacc, input int last_idx);
    exp_line = '0;
    for (int k = 0; k < nacc; k++) begin
      int idx;
      logic [DW-1:0] w;
      idx = (off + k) % N;
      w = beat_words[k];
      if (sen && idx == soff) w = byte_merge(w, swd, sws);
      exp_line[idx*DW +: DW] = w;
      if (k == 0) exp_crit = w;
    end
    exp_err = (last_idx != N - 1);
  endtask

  task automatic applyStimulus(input int off, input bit sen, input int soff, input logic [DW-1:0] swd,
                               input logic [3:0] sws, input int last_idx, input bit gaps,
                               input int ready_delay);
    int  nacc;
    bit  crit_low_pending;
    logic [LW-1:0] held;
    nacc = (last_idx >= 0 && last_idx < N - 1) ? last_idx + 1 : N;
    build_model(off, sen, soff, swd, sws, nacc, last_idx);

    checkOutput("start_ready_idle", start_ready, 1);
    start_valid  = 1'b1;
    start_offset = AW'(off);
    st_en        = sen;
    st_offset    = AW'(soff);
    st_wdata     = swd;
    st_wstrb     = sws;
    step();
    start_valid = 1'b0;
    st_en       = $urandom_range(0, 1);
    st_offset   = AW'($urandom);
    st_wdata    = $urandom;
    st_wstrb    = 4'($urandom);
    checkOutput("beat_ready_fill", beat_ready, 1);
    checkOutput("start_ready_fill", start_ready, 0);

    crit_low_pending = 1'b0;
    for (int k = 0; k < nacc; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        beat_valid = 1'b0;
        beat_data  = $urandom;
        beat_last  = $urandom_range(0, 1);
        step();
        if (crit_low_pending) begin
          checkOutput("crit_pulse_once", crit_valid, 0);
          crit_low_pending = 1'b0;
        end
      end
      beat_valid = 1'b1;
      beat_data  = beat_words[k];
      beat_last  = (k == last_idx);
      step();
      if (crit_low_pending) begin
        checkOutput("crit_pulse_once", crit_valid, 0);
        crit_low_pending = 1'b0;
      end
      if (k == 0) begin
        checkOutput("crit_valid", crit_valid, 1);
        checkOutput("crit_data", crit_data, exp_crit);
        crit_low_pending = 1'b1;
      end
      if (k < nacc - 1) checkOutput("line_valid_early", line_valid, 0);
    end

    // One cycle after the final accepted beat the line must be presented.
    checkOutput("line_valid", line_valid, 1);
    checkOutput("line_data", line_data, exp_line);
    checkOutput("err", err, exp_err);
    checkOutput("beat_ready_done", beat_ready, 0);

    beat_valid = 1'b1;
    beat_data  = $urandom;
    beat_last  = 1'b0;
    held = line_data;
    step();
    if (crit_low_pending) checkOutput("crit_pulse_once", crit_valid, 0);
    beat_valid = 1'b0;
    checkOutput("extra_beat_ignored", line_data, held);

    for (int d = 0; d < ready_delay; d++) begin
      line_ready  = 1'b0;
      start_valid = $urandom_range(0, 1);
      step();
      checkOutput("bp_line_valid", line_valid, 1);
      checkOutput("bp_line_data", line_data, exp_line);
      checkOutput("bp_start_ready", start_ready, 0);
    end

    line_ready  = 1'b1;
    start_valid = 1'b1;
    step();
    line_ready  = 1'b0;
    start_valid = 1'b0;
    checkOutput("line_valid_drop", line_valid, 0);
    checkOutput("start_ready_back", start_ready, 1);
    checkOutput("err_sticky", err, exp_err);
  endtask

  initial begin
    int off;
    int soff;
    int last_idx;
    rst = 1'b1; start_valid = 1'b0; start_offset = '0; st_en = 1'b0; st_offset = '0;
    st_wdata = '0; st_wstrb = '0; beat_valid = 1'b0; beat_data = '0; beat_last = 1'b0;
    line_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_start_ready", start_ready, 1);
    checkOutput("rst_line_valid", line_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_crit_valid", crit_valid, 0);
    checkOutput("rst_crit_data", crit_data, 0);
    checkOutput("rst_line_data", line_data, 0);

    $display("[TB] aligned fill");
    for (int k = 0; k < N; k++) beat_words[k] = 32'h1000 + k;
    applyStimulus(0, 1'b0, 0, 32'h0, 4'h0, N - 1, 1'b0, 0);
    checkOutput("aligned_crit_const", crit_data, 32'h1000);

    $display("[TB] wrapped fill");
    for (int k = 0; k < N; k++) beat_words[k] = 32'hA0 + k;
    applyStimulus(13, 1'b0, 0, 32'h0, 4'h0, N - 1, 1'b0, 1);
    checkOutput("wrap_crit_const", crit_data, 32'hA0);
    checkOutput("wrap_word0_const", line_data[0 +: DW], 32'hA3);
    checkOutput("wrap_word12_const", line_data[12*DW +: DW], 32'hAF);

    $display("[TB] store merge");
    for (int k = 0; k < N; k++) beat_words[k] = $urandom;
    beat_words[3] = 32'h11223344;
    applyStimulus(2, 1'b1, 5, 32'hDEADBEEF, 4'b0101, N - 1, 1'b1, 0);
    checkOutput("merge_word5_const", line_data[5*DW +: DW], 32'h11AD33EF);

    $display("[TB] early last");
    for (int k = 0; k < N; k++) beat_words[k] = $urandom | 32'h1;
    applyStimulus(0, 1'b0, 0, 32'h0, 4'h0, 9, 1'b0, 2);
    checkOutput("early_err_idle", err, 1);
    for (int k = 0; k < N; k++) beat_words[k] = $urandom;
    applyStimulus(7, 1'b0, 0, 32'h0, 4'h0, N - 1, 1'b0, 0);
    checkOutput("clean_clears_err", err, 0);

    $display("[TB] missing last with back-pressure");
    for (int k = 0; k < N; k++) beat_words[k] = $urandom;
    applyStimulus(4, 1'b1, 4, $urandom, 4'hF, -1, 1'b0, 5);

    $display("[TB] reset mid-fill");
    start_valid  = 1'b1;
    start_offset = AW'(3);
    step();
    start_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      beat_valid = 1'b1;
      beat_data  = $urandom | 32'h1;
      beat_last  = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat_valid = 1'b0;
    checkOutput("midrst_start_ready", start_ready, 1);
    checkOutput("midrst_beat_ready", beat_ready, 0);
    checkOutput("midrst_line_valid", line_valid, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_line_data", line_data, 0);

    $display("[TB] randomized fills");
    for (int it = 0; it < 24; it++) begin
      int mode;
      off  = $urandom_range(0, N - 1);
      soff = $urandom_range(0, N - 1);
      mode = $urandom_range(0, 9);
      if (mode < 7)      last_idx = N - 1;
      else if (mode < 9) last_idx = $urandom_range(0, N - 2);
      else               last_idx = -1;
      for (int k = 0; k < N; k++) beat_words[k] = $urandom;
      applyStimulus(off, $urandom_range(0, 1), soff, $urandom, 4'($urandom),
                    last_idx, 1'b1, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
